mac_rx_gmii: RTL

- GbE receive MAC, the receive-side counterpart of the team's GMII transmit path.
- Consumes the 8-bit GMII stream produced by the RGMII-to-GMII converter from the PHY.
- Strips preamble/SFD, checks the IEEE 802.3 CRC-32 and strips the FCS.
- Presents frame bytes (DA through payload) to the packet parser with per-frame status.

---
 rtl/mac_rx_gmii.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mac_rx_gmii.sv
// GbE receive MAC (GMII side).
// Strips preamble/SFD, checks the IEEE 802.3 CRC-32 and strips the FCS.
// Delivers DA..payload to the packet parser with per-frame status.
module mac_rx_gmii #(
  parameter int MAX_FRAME_LEN = 9018,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MIN_PREAMBLE  = 1,
  parameter int LEN_W         = 14
) (
  input  logic             clk,
  input  logic             Reset_n_i,
  input  logic             GMII_RX_DV_i,
  input  logic             GMII_RX_ER_i,
  input  logic [7:0]       GMII_RX_RXD_i,
  output logic [7:0]       Data_out,
  output logic             Data_valid,
  output logic             Frame_start,
  output logic             Frame_end,
  output logic [LEN_W-1:0] Frame_len,
  output logic             Crc_ok,
  output logic             Frame_err,
  output logic             Busy
);

  localparam logic [31:0]      CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT     = LEN_W'(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_FCS     = LEN_W'(4);
  localparam logic [7:0]       PRE_MIN     = 8'(MIN_PREAMBLE);
  localparam logic [7:0]       PRE_BYTE    = 8'h55;
  localparam logic [7:0]       SFD_BYTE    = 8'hD5;

  typedef enum logic [2:0] {
    S_RESYNC,
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_OVERSIZE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       pre_cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [31:0]      crc_q;
  logic [7:0]       byte_p0, byte_p1, byte_p2, byte_p3;
  logic             sfd_ok;

  // MSB-first CRC-32 register update for one byte, bit d[7] shifted in first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0000_0000);
    end
    return c;
  endfunction

  // GMII bytes arrive LSB-first on the wire; reverse so the MSB-first register sees wire order.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic in_frame(input state_t s);
    return (s == S_DATA) || (s == S_OVERSIZE);
  endfunction

  assign sfd_ok = (GMII_RX_RXD_i == SFD_BYTE) && (pre_cnt_q >= PRE_MIN);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESYNC:   if (!GMII_RX_DV_i) state_d = S_IDLE;
      S_IDLE:     if (GMII_RX_DV_i) state_d = (GMII_RX_RXD_i == PRE_BYTE) ? S_PREAMBLE : S_RESYNC;
      S_PREAMBLE: begin
        if (!GMII_RX_DV_i)                    state_d = S_IDLE;
        else if (GMII_RX_RXD_i == PRE_BYTE)   state_d = S_PREAMBLE;
        else if (sfd_ok)                      state_d = S_DATA;
        else                                  state_d = S_RESYNC;
      end
      S_DATA: begin
        if (!GMII_RX_DV_i)                    state_d = S_IDLE;
        else if (len_q >= LEN_MAX)            state_d = S_OVERSIZE;
      end
      S_OVERSIZE: if (!GMII_RX_DV_i) state_d = S_IDLE;
      default:    state_d = S_RESYNC;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset_n_i) begin
    if (!Reset_n_i) state_q <= S_RESYNC;
    else            state_q <= state_d;
  end

  // Four-byte delay line that holds back the FCS; stage 0 is the newest byte.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && GMII_RX_DV_i) begin
      byte_p0 <= GMII_RX_RXD_i;
      byte_p1 <= byte_p0;
      byte_p2 <= byte_p1;
      byte_p3 <= byte_p2;
    end
  end

  // Frame counters, CRC accumulation and registered outputs.
  always_ff @(posedge clk or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      pre_cnt_q   <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      crc_q       <= 32'hFFFF_FFFF;
      Data_out    <= '0;
      Data_valid  <= 1'b0;
      Frame_start <= 1'b0;
      Frame_end   <= 1'b0;
      Frame_len   <= '0;
      Crc_ok      <= 1'b0;
      Frame_err   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Data_valid  <= 1'b0;
      Frame_start <= 1'b0;
      Frame_end   <= 1'b0;
      Busy        <= in_frame(state_q) || in_frame(state_d);
      case (state_q)
        S_IDLE: pre_cnt_q <= 8'd1;
        S_PREAMBLE: begin
          if (GMII_RX_DV_i && GMII_RX_RXD_i == PRE_BYTE && pre_cnt_q != 8'hFF)
            pre_cnt_q <= pre_cnt_q + 8'd1;
          if (GMII_RX_DV_i && sfd_ok) begin
            crc_q <= 32'hFFFF_FFFF;
            len_q <= '0;
            err_q <= GMII_RX_ER_i;
          end
        end
        S_DATA: begin
          if (GMII_RX_DV_i) begin
            if (len_q >= LEN_MAX) begin
              len_q <= LEN_SAT;
              err_q <= 1'b1;
            end else begin
              len_q <= len_q + LEN_W'(1);
              err_q <= err_q | GMII_RX_ER_i;
              crc_q <= crc32_d8(crc_q, bitrev8(GMII_RX_RXD_i));
              if (len_q >= LEN_FCS) begin
                Data_out    <= byte_p3;
                Data_valid  <= 1'b1;
                Frame_start <= (len_q == LEN_FCS);
              end
            end
          end else begin
            Frame_end <= 1'b1;
            Frame_len <= len_q;
            Crc_ok    <= (len_q >= LEN_FCS) && (crc_q == CRC_RESIDUE);
            Frame_err <= err_q || (len_q < LEN_MIN);
          end
        end
        S_OVERSIZE: begin
          if (!GMII_RX_DV_i) begin
            Frame_end <= 1'b1;
            Frame_len <= len_q;
            Crc_ok    <= 1'b0;
            Frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
